// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM stage data path.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD2 = 2'b11
  } size_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  // Align the addressed lane down to bit 0, then sign/zero extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size_t'(size))
      SZ_BYTE: load_extend = is_unsigned ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] lane,
                                              input logic [1:0] size);
    case (size_t'(size))
      SZ_BYTE: byte_enables = 4'b0001 << lane;
      SZ_HALF: byte_enables = 4'b0011 << lane;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [31:0] data,
                                                  input logic [1:0]  size);
    case (size_t'(size))
      SZ_BYTE: store_replicate = {4{data[7:0]}};
      SZ_HALF: store_replicate = {2{data[15:0]}};
      default: store_replicate = data;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] lane,
                                      input logic [1:0] size);
    case (size_t'(size))
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      default: misaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_be_ram.sv
// Word-organised data RAM: byte-enable synchronous write, asynchronous read.
// Contents are intentionally not reset.
module mem_be_ram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage with wait-stated data memory and MEM/WB register.
// Holds address decode, fault detection, wait-state FSM and stall generation.
module mem_stage_ws
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEST_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data_in,
  output logic              mem_stall,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DEST_W-1:0] dest,
  output logic [31:0]       alu_result,
  output logic [31:0]       load_data,
  output logic              fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  logic [31:0]   offset;
  logic [1:0]    lane;
  logic          access, fault_c, valid_acc;
  logic [31:0]   rdata, ld_ext;
  logic          ram_we;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          stall_c, complete;

  // Addresses below BASE_ADDR wrap to large offsets and land in the range fault.
  assign offset    = alu_result_in - 32'(BASE_ADDR);
  assign lane      = offset[1:0];
  assign access    = mem_r_en_in | mem_w_en_in;
  assign fault_c   = access & ((offset >= 32'(4 * DEPTH_WORDS)) | misaligned(lane, size_in));
  assign valid_acc = access & ~fault_c;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_acc) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
            stall_c   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
          stall_c = 1'b1;
        end else begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_stall = stall_c & ~rst;
  assign ram_we    = complete & mem_w_en_in & ~rst;
  assign ld_ext    = load_extend(rdata, lane, size_in, unsigned_in);

  mem_be_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (byte_enables(lane, size_in)),
    .addr (offset[AW+1:2]),
    .wdata(store_replicate(store_data_in, size_in)),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      fault      <= 1'b0;
      dest       <= '0;
      alu_result <= '0;
      load_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (mem_stall) begin
        wb_en    <= 1'b0;
        mem_r_en <= 1'b0;
        fault    <= 1'b0;
      end else begin
        wb_en      <= wb_en_in;
        mem_r_en   <= mem_r_en_in;
        dest       <= dest_in;
        alu_result <= alu_result_in;
        load_data  <= (complete & mem_r_en_in) ? ld_ext : '0;
        fault      <= fault_c;
      end
    end
  end

  a_hold_inputs: assert property (@(posedge clk) disable iff (rst)
    mem_stall |=> $stable({wb_en_in, mem_r_en_in, mem_w_en_in, size_in, unsigned_in,
                           dest_in, alu_result_in, store_data_in}));

endmodule

// File: tb/tb_mem_stage_ws.sv
// Scoreboard bench: stage A has two wait states, stage B none.
module tb_mem_stage_ws;
  import mem_pkg::*;

  typedef struct {
    logic        wb;
    logic        rd;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        flt;
    int          st;
  } exp_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_wb_in, a_rd_in, a_wr_in, a_us_in;
  logic [1:0] a_sz_in;
  logic [4:0] a_dest_in;
  logic [31:0] a_alu_in, a_sd_in;
  logic a_stall, a_wb, a_rd, a_flt;
  logic [4:0] a_dest;
  logic [31:0] a_alu, a_ld;

  logic b_rst, b_wb_in, b_rd_in, b_wr_in, b_us_in;
  logic [1:0] b_sz_in;
  logic [4:0] b_dest_in;
  logic [31:0] b_alu_in, b_sd_in;
  logic b_stall, b_wb, b_rd, b_flt;
  logic [4:0] b_dest;
  logic [31:0] b_alu, b_ld;

  mem_stage_ws #(.DEPTH_WORDS(1024), .BASE_ADDR(1024), .WAIT_CYCLES(2), .DEST_W(5)) dut_a (
    .clk(clk), .rst(a_rst), .wb_en_in(a_wb_in), .mem_r_en_in(a_rd_in), .mem_w_en_in(a_wr_in),
    .size_in(a_sz_in), .unsigned_in(a_us_in), .dest_in(a_dest_in), .alu_result_in(a_alu_in),
    .store_data_in(a_sd_in), .mem_stall(a_stall), .wb_en(a_wb), .mem_r_en(a_rd), .dest(a_dest),
    .alu_result(a_alu), .load_data(a_ld), .fault(a_flt));

  mem_stage_ws #(.DEPTH_WORDS(1024), .BASE_ADDR(1024), .WAIT_CYCLES(0), .DEST_W(5)) dut_b (
    .clk(clk), .rst(b_rst), .wb_en_in(b_wb_in), .mem_r_en_in(b_rd_in), .mem_w_en_in(b_wr_in),
    .size_in(b_sz_in), .unsigned_in(b_us_in), .dest_in(b_dest_in), .alu_result_in(b_alu_in),
    .store_data_in(b_sd_in), .mem_stall(b_stall), .wb_en(b_wb), .mem_r_en(b_rd), .dest(b_dest),
    .alu_result(b_alu), .load_data(b_ld), .fault(b_flt));

  exp_t qa[$];
  exp_t qb[$];
  int passed = 0;
  int total = 0;
  int run_a = 0;
  int run_b = 0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;
  logic wd = 1'b0;

  // ---------------- stimulus, stage A ----------------
  task automatic set_a(input logic wb, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic us, input logic [4:0] d, input logic [31:0] addr,
                       input logic [31:0] sd);
    a_wb_in = wb; a_rd_in = rd; a_wr_in = wr; a_sz_in = sz;
    a_us_in = us; a_dest_in = d; a_alu_in = addr; a_sd_in = sd;
  endtask

  task automatic issue_a(input logic wb, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic us, input logic [4:0] d, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] ld, input logic flt,
                         input int st);
    exp_t e;
    set_a(wb, rd, wr, sz, us, d, addr, sd);
    e.wb = wb; e.rd = rd; e.dest = d; e.alu = addr; e.ld = ld; e.flt = flt; e.st = st;
    qa.push_back(e);
    #1;
    for (int k = 0; k < 16 && a_stall; k++) @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b1;
    set_a(0, 0, 0, SZ_WORD, 0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    // establish word i = i for the words exercised below
    for (int i = 0; i < 4; i++)
      issue_a(0, 0, 1, SZ_WORD, 0, 5'd0, 32'(1024 + 4*i), 32'(i), 32'd0, 0, 2);
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd3, 32'd1032, 32'd0, 32'd2, 0, 2);
    // reset during the second stall cycle of a store
    set_a(0, 0, 1, SZ_WORD, 0, 5'd0, 32'd1024, 32'hDEADBEEF);
    #1;
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd4, 32'd1024, 32'd0, 32'd0, 0, 2);
    issue_a(0, 0, 1, SZ_BYTE, 0, 5'd0, 32'd1037, 32'h000000A5, 32'd0, 0, 2);
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd5, 32'd1036, 32'd0, 32'h0000A503, 0, 2);
    issue_a(1, 1, 0, SZ_BYTE, 0, 5'd6, 32'd1037, 32'd0, 32'hFFFFFFA5, 0, 2);
    issue_a(1, 1, 0, SZ_BYTE, 1, 5'd7, 32'd1037, 32'd0, 32'h000000A5, 0, 2);
    issue_a(0, 0, 1, SZ_HALF, 0, 5'd0, 32'd1026, 32'h00008001, 32'd0, 0, 2);
    issue_a(1, 1, 0, SZ_HALF, 0, 5'd8, 32'd1026, 32'd0, 32'hFFFF8001, 0, 2);
    issue_a(1, 1, 0, SZ_HALF, 1, 5'd9, 32'd1026, 32'd0, 32'h00008001, 0, 2);
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd10, 32'd1024, 32'd0, 32'h80010000, 0, 2);
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd11, 32'd1025, 32'd0, 32'd0, 1, 0);
    issue_a(0, 0, 1, SZ_WORD, 0, 5'd0, 32'd1020, 32'h12345678, 32'd0, 1, 0);
    issue_a(1, 1, 0, SZ_HALF, 0, 5'd12, 32'd1027, 32'd0, 32'd0, 1, 0);
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd13, 32'd1024, 32'd0, 32'h80010000, 0, 2);
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd14, 32'd1036, 32'd0, 32'h0000A503, 0, 2);
    issue_a(1, 0, 0, SZ_WORD, 0, 5'd15, 32'h0000ABCD, 32'd0, 32'd0, 0, 0);
    issue_a(1, 1, 0, SZ_WORD, 0, 5'd16, 32'd5120, 32'd0, 32'd0, 1, 0);
    a_rst = 1'b1;
    set_a(0, 0, 0, SZ_WORD, 0, 5'd0, 32'd0, 32'd0);
    done_a = 1'b1;
  end

  // ---------------- stimulus, stage B (no wait states) ----------------
  task automatic issue_b(input logic wb, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic us, input logic [4:0] d, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] ld);
    exp_t e;
    b_wb_in = wb; b_rd_in = rd; b_wr_in = wr; b_sz_in = sz;
    b_us_in = us; b_dest_in = d; b_alu_in = addr; b_sd_in = sd;
    e.wb = wb; e.rd = rd; e.dest = d; e.alu = addr; e.ld = ld; e.flt = 1'b0; e.st = 0;
    qb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    b_rst = 1'b1;
    b_wb_in = 0; b_rd_in = 0; b_wr_in = 0; b_sz_in = SZ_WORD;
    b_us_in = 0; b_dest_in = '0; b_alu_in = '0; b_sd_in = '0;
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    issue_b(1, 0, 0, SZ_WORD, 0, 5'd1, 32'h00000011, 32'd0, 32'd0);
    issue_b(0, 0, 1, SZ_WORD, 0, 5'd0, 32'd1040, 32'h12345678, 32'd0);
    issue_b(1, 1, 0, SZ_WORD, 0, 5'd2, 32'd1040, 32'd0, 32'h12345678);
    issue_b(1, 0, 0, SZ_WORD, 0, 5'd3, 32'h00000022, 32'd0, 32'd0);
    issue_b(0, 0, 1, SZ_WORD, 0, 5'd0, 32'd1044, 32'hCAFEF00D, 32'd0);
    issue_b(1, 1, 0, SZ_WORD, 0, 5'd4, 32'd1044, 32'd0, 32'hCAFEF00D);
    issue_b(0, 0, 1, SZ_BYTE, 0, 5'd0, 32'd1041, 32'h0000007F, 32'd0);
    issue_b(1, 1, 0, SZ_BYTE, 0, 5'd5, 32'd1041, 32'd0, 32'h0000007F);
    issue_b(1, 1, 0, SZ_WORD, 0, 5'd6, 32'd1040, 32'd0, 32'h12347F78);
    issue_b(1, 1, 0, SZ_HALF, 0, 5'd7, 32'd1046, 32'd0, 32'hFFFFCAFE);
    b_rst = 1'b1;
    b_wb_in = 0; b_rd_in = 0; b_wr_in = 0;
    done_b = 1'b1;
  end

  initial begin
    repeat (4000) @(posedge clk);
    wd = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endfunction

  function automatic void cmp(input string s, input exp_t e, input logic wb, input logic rd,
                              input logic [4:0] d, input logic [31:0] alu, input logic [31:0] ld,
                              input logic flt, input int run);
    chk({s, " wb_en"}, 96'(wb), 96'(e.wb));
    chk({s, " mem_r_en"}, 96'(rd), 96'(e.rd));
    chk({s, " dest"}, 96'(d), 96'(e.dest));
    chk({s, " alu_result"}, 96'(alu), 96'(e.alu));
    chk({s, " load_data"}, 96'(ld), 96'(e.ld));
    chk({s, " fault"}, 96'(flt), 96'(e.flt));
    chk({s, " stall_cycles"}, 96'(run), 96'(e.st));
  endfunction

  logic pa_stall, pa_rst, pb_stall, pb_rst;
  exp_t ea, eb;

  always @(posedge clk) begin
    pa_stall = a_stall; pa_rst = a_rst;
    pb_stall = b_stall; pb_rst = b_rst;
    #1;
    if (pa_rst) begin
      chk("A stall_in_reset", 96'(pa_stall), 96'(0));
      chk("A reset_outputs", 96'({a_wb, a_rd, a_flt, a_dest, a_alu, a_ld}), 96'(0));
      run_a = 0;
    end else if (pa_stall) begin
      chk("A bubble", 96'({a_wb, a_rd, a_flt}), 96'(0));
      run_a++;
    end else if (qa.size() == 0) begin
      chk("A result_expected", 96'(qa.size()), 96'(1));
    end else begin
      ea = qa.pop_front();
      cmp("A", ea, a_wb, a_rd, a_dest, a_alu, a_ld, a_flt, run_a);
      run_a = 0;
    end

    if (pb_rst) begin
      chk("B stall_in_reset", 96'(pb_stall), 96'(0));
      chk("B reset_outputs", 96'({b_wb, b_rd, b_flt, b_dest, b_alu, b_ld}), 96'(0));
      run_b = 0;
    end else if (pb_stall) begin
      chk("B bubble", 96'({b_wb, b_rd, b_flt}), 96'(0));
      run_b++;
    end else if (qb.size() == 0) begin
      chk("B result_expected", 96'(qb.size()), 96'(1));
    end else begin
      eb = qb.pop_front();
      cmp("B", eb, b_wb, b_rd, b_dest, b_alu, b_ld, b_flt, run_b);
      run_b = 0;
    end

    if ((done_a && done_b) || wd) begin
      chk("timeout", 96'(wd), 96'(0));
      chk("A drain", 96'(qa.size()), 96'(0));
      chk("B drain", 96'(qb.size()), 96'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

endmodule
